// File: rtl/peak_count_readout.sv
// peak_count_readout: frames datapath counts into a byte stream
// Ports:
//   clk, rst                  clock, async active-high reset
//   start                     readout request (IDLE only)
//   count_in, count_vld_in    serialized count word from the datapath
//   overflow_in               per-channel overflow flags
//   sreg_load_en              load the datapath shift register
//   sreg_shift_en             consume current word, advance the datapath
//   out_data, out_vld, out_rdy  byte stream toward the USB side
//   busy, done                frame activity / one-cycle drain pulse
module peak_count_readout #(
    parameter int          CNTR_WIDTH = 8,
    parameter int          CNTR_DEPTH = 24,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNTR_WIDTH-1:0] count_in,
    input  logic                  count_vld_in,
    input  logic [CNTR_DEPTH-1:0] overflow_in,
    output logic                  sreg_load_en,
    output logic                  sreg_shift_en,
    output logic [7:0]            out_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  busy,
    output logic                  done
);

    localparam int OVF_BYTES = (CNTR_DEPTH + 7) / 8;
    localparam int SNAP_W    = OVF_BYTES * 8;
    localparam int WIW       = $clog2(CNTR_DEPTH + 1);
    localparam int OIW       = $clog2(OVF_BYTES + 1);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;

    localparam logic [WIW-1:0] LAST_WORD = WIW'(CNTR_DEPTH - 1);
    localparam logic [OIW-1:0] LAST_OVF  = OIW'(OVF_BYTES - 1);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        WORDS,
        OVF,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic                load_q, load_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [WIW-1:0]      word_q, word_d;
    logic [OIW-1:0]      ovf_q, ovf_d;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                push;
    logic [7:0]          push_data;
    logic                pop;
    logic                full;
    logic                empty;
    logic [7:0]          word_byte;
    logic [SNAP_W-1:0]   snap_sh;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign pop   = ~empty & out_rdy;

    assign out_vld      = ~empty;
    // Gate the head so out_data reads 0 whenever nothing is queued.
    assign out_data     = empty ? 8'h00 : mem_q[rd_q];
    assign sreg_load_en = load_q;
    assign busy         = (state_q != IDLE);

    always_comb begin
        word_byte = '0;
        word_byte[CNTR_WIDTH-1:0] = count_in;
    end

    assign snap_sh = snap_q >> {ovf_q, 3'b000};

    always_comb begin
        state_d       = state_q;
        load_d        = load_q;
        snap_d        = snap_q;
        word_d        = word_q;
        ovf_d         = ovf_q;
        push          = 1'b0;
        push_data     = 8'h00;
        sreg_shift_en = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    load_d  = 1'b1;
                    word_d  = '0;
                    ovf_d   = '0;
                end
            end
            LOAD: begin
                if (count_vld_in) begin
                    load_d = 1'b0;
                    snap_d = '0;
                    snap_d[CNTR_DEPTH-1:0] = overflow_in;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = HEADER;
                    state_d   = WORDS;
                end
            end
            WORDS: begin
                if (count_vld_in && !full) begin
                    sreg_shift_en = 1'b1;
                    push          = 1'b1;
                    push_data     = word_byte;
                    word_d        = word_q + 1'b1;
                    if (word_q == LAST_WORD) begin
                        state_d = OVF;
                    end
                end
            end
            OVF: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = snap_sh[7:0];
                    ovf_d     = ovf_q + 1'b1;
                    if (ovf_q == LAST_OVF) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (empty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                load_d  = 1'b0;
            end
        endcase
    end

    // Push is already gated by ~full, so a pop never frees a slot
    // for a same-cycle push.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            snap_q  <= '0;
            word_q  <= '0;
            ovf_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            snap_q  <= snap_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

endmodule
